// File: rtl/fp_adder_pipe.sv
// fp_adder_pipe: three-stage IEEE-754 adder with valid/ready handshake.
//   S1 unpack/special detect/align, S2 add/normalise, S3 round/pack.
//   Format is set by EXP_W/MAN_W. Define FPADD_SUB_OP_EN to add the
//   op_sub port (B's sign flipped before any processing).
module fp_adder_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] fp_a,
    input  logic [W-1:0] fp_b,
    input  logic [2:0]   r_mode,
`ifdef FPADD_SUB_OP_EN
    input  logic         op_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] fp_result,
    output logic         overflow,
    output logic         underflow,
    output logic         inexact,
    output logic         invalid
);
    // Aligned mantissa layout: hidden, fraction, guard, round, sticky
    localparam int MW = MAN_W + 4;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_MAX  = EXP_ONES - 1'b1;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // ---------------- handshake ----------------
    logic       adv;
    logic [2:0] vld_pipe_q;

    assign adv       = !vld_pipe_q[2] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe_q[2];

    // Valid bits shift together with the data whenever the pipe advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe_q <= '0;
        else if (adv) vld_pipe_q <= {vld_pipe_q[1:0], in_valid};
    end

    // ---------------- S1: unpack / align ----------------
    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, swap;

    assign sa = fp_a[W-1];
`ifdef FPADD_SUB_OP_EN
    assign sb = fp_b[W-1] ^ op_sub;
`else
    assign sb = fp_b[W-1];
`endif
    assign ea = fp_a[W-2:MAN_W];
    assign eb = fp_b[W-2:MAN_W];
    assign fa = fp_a[MAN_W-1:0];
    assign fb = fp_b[MAN_W-1:0];

    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    // Magnitude order is the unsigned order of {exp, frac}
    assign swap   = {eb, fb} > {ea, fa};

    logic             s1_sign_d, s1_sub_d, s1_spec_d, s1_spec_inv_d;
    logic [EXP_W-1:0] s1_exp_d;
    logic [MW-1:0]    s1_big_d, s1_sml_d;
    logic [2:0]       s1_rm_d;
    logic [W-1:0]     s1_spec_res_d;
    logic [EXP_W-1:0] big_e, sml_e, big_ee, sml_ee, d_exp;
    logic [MAN_W-1:0] big_f, sml_f;
    logic [MW-1:0]    sml_m;
    logic [2*MW-1:0]  ext;
    int               shamt;

    // Order operands by magnitude, align the smaller one, detect specials
    always_comb begin
        big_e  = swap ? eb : ea;
        big_f  = swap ? fb : fa;
        sml_e  = swap ? ea : eb;
        sml_f  = swap ? fa : fb;
        big_ee = (big_e == '0) ? EXP_W'(1) : big_e;
        sml_ee = (sml_e == '0) ? EXP_W'(1) : sml_e;
        d_exp  = big_ee - sml_ee;
        shamt  = (int'(d_exp) >= MW) ? MW : int'(d_exp);
        sml_m  = {|sml_e, sml_f, 3'b000};
        // Lower half catches everything shifted past sticky
        ext    = {sml_m, {MW{1'b0}}} >> shamt;

        s1_sign_d = swap ? sb : sa;
        s1_sub_d  = sa ^ sb;
        s1_exp_d  = big_ee;
        s1_big_d  = {|big_e, big_f, 3'b000};
        s1_sml_d  = {ext[2*MW-1:MW+1], ext[MW] | (|ext[MW-1:0])};
        s1_rm_d   = (r_mode > RM_RMM) ? RM_RNE : r_mode;

        s1_spec_d     = 1'b0;
        s1_spec_inv_d = 1'b0;
        s1_spec_res_d = '0;
        if (a_nan || b_nan) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = QNAN;
            s1_spec_inv_d = a_snan || b_snan;
        end else if (a_inf && b_inf && (sa != sb)) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = QNAN;
            s1_spec_inv_d = 1'b1;
        end else if (a_inf) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    logic             s1_sign_q, s1_sub_q, s1_spec_q, s1_spec_inv_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [MW-1:0]    s1_big_q, s1_sml_q;
    logic [2:0]       s1_rm_q;
    logic [W-1:0]     s1_spec_res_q;

    // S1 pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign_q     <= 1'b0;
            s1_sub_q      <= 1'b0;
            s1_spec_q     <= 1'b0;
            s1_spec_inv_q <= 1'b0;
            s1_exp_q      <= '0;
            s1_big_q      <= '0;
            s1_sml_q      <= '0;
            s1_rm_q       <= '0;
            s1_spec_res_q <= '0;
        end else if (adv) begin
            s1_sign_q     <= s1_sign_d;
            s1_sub_q      <= s1_sub_d;
            s1_spec_q     <= s1_spec_d;
            s1_spec_inv_q <= s1_spec_inv_d;
            s1_exp_q      <= s1_exp_d;
            s1_big_q      <= s1_big_d;
            s1_sml_q      <= s1_sml_d;
            s1_rm_q       <= s1_rm_d;
            s1_spec_res_q <= s1_spec_res_d;
        end
    end

    // ---------------- S2: add / normalise ----------------
    logic [MW:0]      sum;
    logic [MW-1:0]    s2_man_d;
    logic [EXP_W-1:0] s2_exp_d;
    logic             s2_sign_d;
    int               lz, sh;

    // Add or subtract aligned mantissas, then normalise (never below exp 1)
    always_comb begin
        sum = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_sml_q})
                       : ({1'b0, s1_big_q} + {1'b0, s1_sml_q});
        s2_sign_d = s1_sign_q;
        s2_exp_d  = s1_exp_q;
        s2_man_d  = sum[MW-1:0];
        lz        = 0;
        sh        = 0;
        if (sum[MW]) begin
            s2_man_d = {sum[MW:2], sum[1] | sum[0]};
            s2_exp_d = s1_exp_q + EXP_W'(1);
        end else if (sum[MW-1:0] == '0) begin
            // Exact zero: cancellation signs as +0 (-0 under RDN)
            s2_man_d  = '0;
            s2_exp_d  = '0;
            s2_sign_d = s1_sub_q ? (s1_rm_q == RM_RDN) : s1_sign_q;
        end else begin
            lz = MW;
            for (int i = 0; i < MW; i++) if (sum[i]) lz = MW - 1 - i;
            sh = (lz < int'(s1_exp_q) - 1) ? lz : int'(s1_exp_q) - 1;
            s2_man_d = sum[MW-1:0] << sh;
            s2_exp_d = s2_man_d[MW-1] ? (s1_exp_q - EXP_W'(sh)) : '0;
        end
    end

    logic             s2_sign_q, s2_spec_q, s2_spec_inv_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [MW-2:0]    s2_man_q;   // hidden bit is implied by exp != 0
    logic [2:0]       s2_rm_q;
    logic [W-1:0]     s2_spec_res_q;

    // S2 pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sign_q     <= 1'b0;
            s2_spec_q     <= 1'b0;
            s2_spec_inv_q <= 1'b0;
            s2_exp_q      <= '0;
            s2_man_q      <= '0;
            s2_rm_q       <= '0;
            s2_spec_res_q <= '0;
        end else if (adv) begin
            s2_sign_q     <= s2_sign_d;
            s2_spec_q     <= s1_spec_q;
            s2_spec_inv_q <= s1_spec_inv_q;
            s2_exp_q      <= s2_exp_d;
            s2_man_q      <= s2_man_d[MW-2:0];
            s2_rm_q       <= s1_rm_q;
            s2_spec_res_q <= s1_spec_res_q;
        end
    end

    // ---------------- S3: round / pack ----------------
    logic                   g, rb, st, lsb, inx, rup, ovf;
    logic [EXP_W+MAN_W:0]   mag;
    logic [W-1:0]           res_d;
    logic                   ovf_d, unf_d, inx_d, inv_d;

    // Round on G/R/S; the {exp,frac} increment carries into the exponent
    always_comb begin
        lsb = s2_man_q[3];
        g   = s2_man_q[2];
        rb  = s2_man_q[1];
        st  = s2_man_q[0];
        inx = g | rb | st;
        case (s2_rm_q)
            RM_RTZ:  rup = 1'b0;
            RM_RDN:  rup = s2_sign_q & inx;
            RM_RUP:  rup = !s2_sign_q & inx;
            RM_RMM:  rup = g;
            default: rup = g & (rb | st | lsb);
        endcase
        mag = {1'b0, s2_exp_q, s2_man_q[MW-2:3]} + {{(EXP_W+MAN_W){1'b0}}, rup};
        ovf = mag[EXP_W+MAN_W] || (mag[EXP_W+MAN_W-1:MAN_W] == EXP_ONES);

        res_d = {s2_sign_q, mag[EXP_W+MAN_W-1:0]};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = inx;
        inv_d = 1'b0;
        if (s2_spec_q) begin
            res_d = s2_spec_res_q;
            inx_d = 1'b0;
            inv_d = s2_spec_inv_q;
        end else if (ovf) begin
            ovf_d = 1'b1;
            inx_d = 1'b1;
            case (s2_rm_q)
                RM_RTZ:  res_d = {s2_sign_q, EXP_MAX, {MAN_W{1'b1}}};
                RM_RUP:  res_d = s2_sign_q ? {1'b1, EXP_MAX, {MAN_W{1'b1}}}
                                           : {1'b0, EXP_ONES, {MAN_W{1'b0}}};
                RM_RDN:  res_d = s2_sign_q ? {1'b1, EXP_ONES, {MAN_W{1'b0}}}
                                           : {1'b0, EXP_MAX, {MAN_W{1'b1}}};
                default: res_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            endcase
        end else begin
            unf_d = (mag[EXP_W+MAN_W-1:MAN_W] == '0) && inx;
        end
    end

    logic [W-1:0] res_q;
    logic         ovf_q, unf_q, inx_q, inv_q;

    // Output register; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            inx_q <= 1'b0;
            inv_q <= 1'b0;
        end else if (adv) begin
            res_q <= res_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            inx_q <= inx_d;
            inv_q <= inv_d;
        end
    end

    assign fp_result = res_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;
    assign invalid   = inv_q;

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed bench for fp_adder_pipe (binary32): vector table plus
// backpressure and mid-stream reset sequences.
module tb_fp_adder_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] fp_a = '0, fp_b = '0;
    logic [2:0]  r_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] fp_result;
    logic        overflow, underflow, inexact, invalid;
`ifdef FPADD_SUB_OP_EN
    logic        op_sub = 1'b0;
`endif

    int errs = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    fp_adder_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fp_a(fp_a), .fp_b(fp_b), .r_mode(r_mode),
`ifdef FPADD_SUB_OP_EN
        .op_sub(op_sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .fp_result(fp_result),
        .overflow(overflow), .underflow(underflow), .inexact(inexact), .invalid(invalid)
    );

    // flags packed as {overflow, underflow, inexact, invalid}
    localparam logic [3:0] F0 = 4'b0000, FX = 4'b0010, FV = 4'b0001, FOX = 4'b1010;

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;
    vec_t vt[$];

    task automatic av(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                      input logic [31:0] r, input logic [3:0] f);
        vec_t v;
        v.a = a; v.b = b; v.rm = rm; v.res = r; v.fl = f;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] flg();
        return {28'b0, overflow, underflow, inexact, invalid};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(posedge clk); #1;
        fp_a = v.a; fp_b = v.b; r_mode = v.rm; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'd3);
        chk($sformatf("v%0d result", idx), fp_result, v.res);
        chk($sformatf("v%0d flags", idx), flg(), {28'b0, v.fl});
    endtask

    logic [31:0] bp_in [5];
    logic [31:0] bp_exp[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // RNE=0 RTZ=1 RDN=2 RUP=3 RMM=4
        av(32'h3F800000, 32'h3F800000, 3'd0, 32'h40000000, F0);
        av(32'h3F800000, 32'hBF800000, 3'd0, 32'h00000000, F0);
        av(32'h3F800000, 32'hBF800000, 3'd2, 32'h80000000, F0);
        av(32'h7F7FFFFF, 32'h7F7FFFFF, 3'd0, 32'h7F800000, FOX);
        av(32'h7F7FFFFF, 32'h7F7FFFFF, 3'd1, 32'h7F7FFFFF, FOX);
        av(32'h7F7FFFFF, 32'h7F7FFFFF, 3'd3, 32'h7F800000, FOX);
        av(32'h7F7FFFFF, 32'h7F7FFFFF, 3'd2, 32'h7F7FFFFF, FOX);
        av(32'hFF7FFFFF, 32'hFF7FFFFF, 3'd3, 32'hFF7FFFFF, FOX);
        av(32'hFF7FFFFF, 32'hFF7FFFFF, 3'd2, 32'hFF800000, FOX);
        av(32'hFF7FFFFF, 32'hFF7FFFFF, 3'd4, 32'hFF800000, FOX);
        av(32'h000A0000, 32'h000A0000, 3'd1, 32'h00140000, F0);
        av(32'h3F800000, 32'h33800000, 3'd0, 32'h3F800000, FX);
        av(32'h3F800000, 32'h33800000, 3'd3, 32'h3F800001, FX);
        av(32'h3F800000, 32'h33800000, 3'd1, 32'h3F800000, FX);
        av(32'h3F800000, 32'h33800000, 3'd4, 32'h3F800001, FX);
        av(32'h3F800000, 32'h33800000, 3'd2, 32'h3F800000, FX);
        av(32'h3F800000, 32'h33800000, 3'd7, 32'h3F800000, FX);
        av(32'h3F800001, 32'h33800000, 3'd0, 32'h3F800002, FX);
        av(32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000, FV);
        av(32'h7F800000, 32'h3F800000, 3'd0, 32'h7F800000, F0);
        av(32'hFF800000, 32'hFF800000, 3'd0, 32'hFF800000, F0);
        av(32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, F0);
        av(32'h3F800000, 32'h7F800001, 3'd0, 32'h7FC00000, FV);
        av(32'h80000000, 32'h80000000, 3'd0, 32'h80000000, F0);
        av(32'h00000000, 32'h80000000, 3'd0, 32'h00000000, F0);
        av(32'h00000000, 32'h80000000, 3'd2, 32'h80000000, F0);
        av(32'h40400000, 32'hBF800000, 3'd0, 32'h40000000, F0);
        av(32'h00800000, 32'h80400000, 3'd0, 32'h00400000, F0);
        av(32'h007FFFFF, 32'h00000001, 3'd0, 32'h00800000, F0);
        av(32'h3F800000, 32'h00000001, 3'd3, 32'h3F800001, FX);
        av(32'h3F800000, 32'h00000001, 3'd0, 32'h3F800000, FX);
        av(32'h3F800000, 32'hBF7FFFFF, 3'd0, 32'h33800000, F0);

        bp_in  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        bp_exp = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst fp_result", fp_result, 32'd0);
        chk("rst flags", flg(), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) run_vec(vt[i], i);

        // backpressure: 5 back-to-back beats, consumer stalls 3 cycles
        @(posedge clk); #1;
        fork
            begin : drv
                logic acc;
                int   g;
                for (int k = 0; k < 5; k++) begin
                    fp_a = bp_in[k]; fp_b = bp_in[k]; r_mode = 3'd0; in_valid = 1'b1;
                    acc = 1'b0;
                    g = 0;
                    while (!acc && g < 20) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk); #1;
                        g++;
                    end
                    if (!acc) chk($sformatf("bp accept beat%0d", k), 32'd0, 32'd1);
                end
                in_valid = 1'b0;
            end
            begin : col
                int n, cyc, stalls;
                n = 0; cyc = 0; stalls = 0;
                while (n < 5 && cyc < 40) begin
                    @(posedge clk); #1;
                    out_ready = !(cyc >= 2 && cyc <= 4);
                    @(negedge clk);
                    if (!out_ready) begin
                        stalls++;
                        chk($sformatf("bp stall%0d in_ready", stalls), 32'(in_ready), 32'd0);
                        chk($sformatf("bp stall%0d out_valid", stalls), 32'(out_valid), 32'd1);
                        chk($sformatf("bp stall%0d hold", stalls), fp_result, bp_exp[n]);
                    end else begin
                        chk($sformatf("bp cyc%0d in_ready", cyc), 32'(in_ready), 32'd1);
                        if (out_valid) begin
                            chk($sformatf("bp result%0d", n), fp_result, bp_exp[n]);
                            n++;
                        end
                    end
                    cyc++;
                end
                chk("bp beat count", 32'(n), 32'd5);
                chk("bp stall count", 32'(stalls), 32'd3);
            end
        join
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp no extra beat", 32'(out_valid), 32'd0);

        // reset while beats are in flight
        fp_a = 32'h3F800000; fp_b = 32'h3F800000; r_mode = 3'd0; in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid pre-reset out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", 32'(out_valid), 32'd0);
        chk("mid reset fp_result", fp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post reset idle%0d", c), 32'(out_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule

// File: doc/fp_adder_pipe.md
Name: fp_adder_pipe

Overview:
Parametrised, pipelined IEEE-754 floating-point adder. It is the successor to the single-precision combinational adder in the ALU: format width is generic, it is pipelined into 3 stages, and it has a valid/ready handshake with backpressure. It adds full IEEE exception flags and directed-rounding overflow saturation. It sits in the ALU datapath between the operand register file and the FPU result arbiter.

Parameters:
EXP_W, 8, exponent field width (8 for binary32, 11 for binary64, 5 for binary16).
MAN_W, 23, stored fraction width (hidden bit not included).
W, EXP_W+MAN_W+1, derived operand width; not to be overridden.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts a beat this cycle
fp_a  in  W  operand A
fp_b  in  W  operand B
r_mode  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
fp_result  out  W  packed sum
overflow  out  1  rounded magnitude exceeded max finite
underflow  out  1  result tiny (after rounding) and inexact
inexact  out  1  rounded result differs from exact sum
invalid  out  1  NaN input, or Inf + (-Inf)

Behaviour:
- Reset (async assert, sync deassert handled upstream): all stage valid bits, out_valid, fp_result and all flags go to 0. A beat in flight is discarded.
- Pipeline advance: adv = !out_valid || out_ready. All stages shift together when adv=1. in_ready = adv (combinational). The block never drops or duplicates a beat.
- Latency is exactly 3 cycles from an accepted beat to out_valid, with no stall. Throughput is 1 beat per cycle. Bubbles propagate as valid=0.
- S1 (unpack/align):
  - Hidden bit = |exp.
  - Subnormals use effective exponent 1.
  - The larger-magnitude operand is placed as the first operand.
  - The smaller mantissa is right-shifted by the exponent difference into MAN_W+4 bits (hidden bit, fraction, guard, round, sticky). Bits shifted past sticky are OR-ed into sticky.
  - A shift of MAN_W+3 or more leaves only the sticky bit.
  - r_mode is captured with the beat and travels with it.
- S2 (add/normalise):
  - Equal signs add the mantissas; unequal signs subtract smaller from larger. The sign is the sign of the larger magnitude.
  - On carry-out: shift right 1 (keeping sticky) and increment the exponent.
  - Otherwise: count leading zeros and shift left by min(lzc, exp-1). If the result stays subnormal, the exponent field is 0.
- S3 (round/pack):
  - Rounding is applied on G/R/S per r_mode.
  - RNE: ties go to even.
  - RMM: ties go away from zero.
  - RUP/RDN: direction is by sign.
  - Mantissa rounding carry increments the exponent; a subnormal can round up to the minimum normal.
- Overflow (biased exponent reaches all-ones): overflow=1 and inexact=1. Result by mode:
  - RNE, RMM: ±Inf.
  - RTZ: ±max finite.
  - RUP: +Inf for positive, -max finite for negative.
  - RDN: -Inf for negative, +max finite for positive.
- Exact cancellation gives +0, or -0 under RDN.
- (-0)+(-0) = -0; (+0)+(-0) follows the cancellation rule.
- Specials bypass the arithmetic but keep the same 3-cycle latency:
  - Any NaN input gives canonical qNaN (sign 0, exp all-ones, fraction MSB only), invalid=1 only for sNaN.
  - Inf + (-Inf) gives canonical qNaN with invalid=1.
  - Inf + finite, or Inf + same-sign Inf, gives that Inf with no flags.
- Flags are registered alongside fp_result and are valid only while out_valid=1.
- fp_result and flags hold stable while out_valid=1 and out_ready=0.

Optional Feature:
Macro: FPADD_SUB_OP_EN.
- Defined: adds port "op_sub in 1", sampled with the beat. When 1, the sign of B is inverted in S1 before all processing, including special-case rules. For NaN B the inversion has no effect on the result.
- Undefined: the port is absent and the block always adds. Area and timing are identical to an adder with op_sub tied to 0.

Test Plan:
- binary32, RNE: 0x3F800000+0x3F800000 -> 0x40000000 after exactly 3 cycles, all flags 0.
- 0x3F800000+0xBF800000: RNE -> 0x00000000; RDN -> 0x80000000; flags 0.
- 0x7F7FFFFF+0x7F7FFFFF: RNE -> 0x7F800000 with overflow=1, inexact=1; RTZ -> 0x7F7FFFFF with overflow=1.
- Subnormals, RTZ: 0x000A0000+0x000A0000 -> 0x00140000, underflow=0. Tie 0x3F800000+0x33800000: RNE -> 0x3F800000 with inexact=1; RUP -> 0x3F800001.
- Inf+(-Inf): 0x7F800000+0xFF800000 -> 0x7FC00000 with invalid=1. 0x7F800000+0x3F800000 -> 0x7F800000 with no flags.
- Backpressure: issue 5 back-to-back beats and hold out_ready=0 for 3 cycles mid-stream. Required: in_ready falls the cycle out_valid&&!out_ready, outputs hold stable, all 5 results arrive in order with none lost. Assert rst_n low mid-stream: out_valid=0 immediately.
